// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an NxN systolic matmul array.
//
// Collects one A tile (column beats) and one B tile (row beats) from the host.
// Replays them into the array with diagonal skew, captures N result rows from
// the array bottom edge at a fixed latency, then returns those rows to the host
// over a valid/ready port. One tile is in flight at a time.
//
// Optional feature macro: SYSTOLIC_CTRL_PERF_EN adds the perf_cycles output.
//
// Ports
//   clk, reset      clock (rising edge), asynchronous active-low reset
//   start           begin a tile, sampled only while idle
//   busy            high whenever the sequencer is not idle
//   done            one-cycle pulse after the last result row is accepted
//   in_valid        operand beat valid (host -> ctrl)
//   in_ready        operand beat ready, high only while filling
//   in_a_col        beat k: lane i = A[i][k]
//   in_b_row        beat k: lane j = B[k][j]
//   arr_clear       clears array accumulators
//   arr_load        array load/enable, high while feeding
//   arr_vals        skewed A lanes to the array
//   arr_weights     skewed B lanes to the array
//   arr_result      array bottom-edge sums
//   res_valid       result row valid (ctrl -> host)
//   res_ready       host accepts result row
//   res_row         result row r, lane c = C[r][c]
//   perf_cycles     (SYSTOLIC_CTRL_PERF_EN only) busy-cycle count of the last tile

module systolic_ctrl #(
    parameter int unsigned ARRAY_SIZE = 4,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned SUM_WIDTH  = DATA_WIDTH * DATA_WIDTH,
    parameter int unsigned RESULT_LAT = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]    in_a_col,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]    in_b_row,
    output logic                                arr_clear,
    output logic                                arr_load,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]    arr_vals,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]    arr_weights,
    input  logic [ARRAY_SIZE*SUM_WIDTH-1:0]     arr_result,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [ARRAY_SIZE*SUM_WIDTH-1:0]     res_row
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]                         perf_cycles
`endif
);

    localparam int unsigned N        = ARRAY_SIZE;
    localparam int unsigned DW       = DATA_WIDTH;
    localparam int unsigned SW       = SUM_WIDTH;
    localparam int unsigned FEED_CYC = 2 * N - 1;
    localparam int unsigned CAP_LAST = RESULT_LAT + N - 1;
    localparam int unsigned IW       = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned GW       = $clog2(FEED_CYC + CAP_LAST + 2);
    // Short latencies land every row before FEED ends; DRAIN is then skipped.
    localparam bit          CAP_IN_FEED = (CAP_LAST < FEED_CYC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_UNLOAD = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   beat_cnt;
    logic [IW-1:0]   beat_nxt;
    logic [IW-1:0]   rd_cnt;
    logic [IW-1:0]   rd_nxt;
    logic [IW-1:0]   cap_idx;
    logic [GW-1:0]   g_cnt;
    logic [GW-1:0]   g_nxt;
    logic            fill_we;
    logic            cap_en;
    logic            done_nxt;

    logic [N*DW-1:0] vals_nxt;
    logic [N*DW-1:0] weights_nxt;
    logic [N*SW-1:0] res_row_nxt;

    // Tile storage: one packed beat per entry, lanes as delivered by the host.
    logic [N*DW-1:0] a_col_buf [N];
    logic [N*DW-1:0] b_row_buf [N];
    logic [N*SW-1:0] row_buf   [N];

    // Next-state, counters and capture/handshake strobes.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        g_nxt     = g_cnt;
        rd_nxt    = rd_cnt;
        done_nxt  = 1'b0;
        fill_we   = 1'b0;
        cap_en    = ((state == S_FEED) || (state == S_DRAIN)) &&
                    (g_cnt >= GW'(RESULT_LAT)) && (g_cnt <= GW'(CAP_LAST));
        cap_idx   = IW'(g_cnt - GW'(RESULT_LAT));

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FILL;
                    beat_nxt  = '0;
                    g_nxt     = '0;
                    rd_nxt    = '0;
                end
            end
            S_FILL: begin
                if (in_valid) begin
                    fill_we = 1'b1;
                    if (beat_cnt == IW'(N - 1)) begin
                        state_nxt = S_FEED;
                        beat_nxt  = '0;
                        g_nxt     = '0;
                    end else begin
                        beat_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            S_FEED: begin
                g_nxt = g_cnt + 1'b1;
                if (g_cnt == GW'(FEED_CYC - 1)) begin
                    state_nxt = CAP_IN_FEED ? S_UNLOAD : S_DRAIN;
                end
            end
            S_DRAIN: begin
                g_nxt = g_cnt + 1'b1;
                if (g_cnt == GW'(CAP_LAST)) begin
                    state_nxt = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                if (res_ready) begin
                    if (rd_cnt == IW'(N - 1)) begin
                        state_nxt = S_IDLE;
                        rd_nxt    = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        rd_nxt = rd_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Skewed lanes for the upcoming FEED cycle t = g_nxt: lane i carries beat t-i.
    // The beat being written this edge is forwarded so the newest beat is usable
    // on the very next cycle.
    always_comb begin
        vals_nxt    = '0;
        weights_nxt = '0;
        if (state_nxt == S_FEED) begin
            for (int i = 0; i < int'(N); i++) begin
                if ((int'(g_nxt) >= i) && ((int'(g_nxt) - i) < int'(N))) begin
                    if (fill_we && (beat_cnt == IW'(int'(g_nxt) - i))) begin
                        vals_nxt[i*DW +: DW]    = in_a_col[i*DW +: DW];
                        weights_nxt[i*DW +: DW] = in_b_row[i*DW +: DW];
                    end else begin
                        vals_nxt[i*DW +: DW]    = a_col_buf[IW'(int'(g_nxt) - i)][i*DW +: DW];
                        weights_nxt[i*DW +: DW] = b_row_buf[IW'(int'(g_nxt) - i)][i*DW +: DW];
                    end
                end
            end
        end
    end

    // Row presented to the host next cycle; bypasses a row captured this edge.
    always_comb begin
        res_row_nxt = '0;
        if (state_nxt == S_UNLOAD) begin
            if (cap_en && (cap_idx == rd_nxt)) begin
                res_row_nxt = arr_result;
            end else begin
                res_row_nxt = row_buf[rd_nxt];
            end
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            beat_cnt    <= '0;
            g_cnt       <= '0;
            rd_cnt      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            in_ready    <= 1'b0;
            arr_clear   <= 1'b0;
            arr_load    <= 1'b0;
            arr_vals    <= '0;
            arr_weights <= '0;
            res_valid   <= 1'b0;
            res_row     <= '0;
        end else begin
            state       <= state_nxt;
            beat_cnt    <= beat_nxt;
            g_cnt       <= g_nxt;
            rd_cnt      <= rd_nxt;
            busy        <= (state_nxt != S_IDLE);
            done        <= done_nxt;
            in_ready    <= (state_nxt == S_FILL);
            arr_clear   <= (state_nxt == S_IDLE) || (state_nxt == S_FILL);
            arr_load    <= (state_nxt == S_FEED);
            arr_vals    <= vals_nxt;
            arr_weights <= weights_nxt;
            res_valid   <= (state_nxt == S_UNLOAD);
            res_row     <= res_row_nxt;
        end
    end

    // Tile and result buffers hold data only; their reset value is irrelevant.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            a_col_buf[beat_cnt] <= in_a_col;
            b_row_buf[beat_cnt] <= in_b_row;
        end
        if (cap_en) begin
            row_buf[cap_idx] <= arr_result;
        end
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    // Busy-cycle counter: cleared on start accept, frozen while idle, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                perf_cycles <= '0;
            end
        end else if (perf_cycles != 32'hFFFF_FFFF) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: array model with fixed latency, result scoreboard,
// one task per scenario.

module tb_systolic_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 4;
    localparam int unsigned SW = 16;
    localparam int unsigned RL = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            busy;
    logic            done;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_a_col;
    logic [N*DW-1:0] in_b_row;
    logic            arr_clear;
    logic            arr_load;
    logic [N*DW-1:0] arr_vals;
    logic [N*DW-1:0] arr_weights;
    logic [N*SW-1:0] arr_result;
    logic            res_valid;
    logic            res_ready;
    logic [N*SW-1:0] res_row;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]     perf_cycles;
`endif

    systolic_ctrl #(
        .ARRAY_SIZE (N),
        .DATA_WIDTH (DW),
        .SUM_WIDTH  (SW),
        .RESULT_LAT (RL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a_col    (in_a_col),
        .in_b_row    (in_b_row),
        .arr_clear   (arr_clear),
        .arr_load    (arr_load),
        .arr_vals    (arr_vals),
        .arr_weights (arr_weights),
        .arr_result  (arr_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_row     (res_row)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int              checks = 0;
    int              errors = 0;
    logic [N*SW-1:0] exp_q [$];
    logic [DW-1:0]   a_mat [N][N];
    logic [DW-1:0]   b_mat [N][N];
    logic [SW-1:0]   tile_seed;
    int              g;
    bit              g_act;

    // Result row r of a tile: lane c = seed + r + c (wraps, so negative sums occur).
    function automatic logic [N*SW-1:0] row_val(input logic [SW-1:0] seed, input int r);
        logic [N*SW-1:0] v;
        for (int c = 0; c < int'(N); c++) v[c*SW +: SW] = seed + SW'(r + c);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_vals(input int t);
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < int'(N); i++)
            if (t >= i && t - i < int'(N)) v[i*DW +: DW] = a_mat[i][t-i];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_weights(input int t);
        logic [N*DW-1:0] v;
        v = '0;
        for (int j = 0; j < int'(N); j++)
            if (t >= j && t - j < int'(N)) v[j*DW +: DW] = b_mat[t-j][j];
        return v;
    endfunction

    // Array model: result row r appears on arr_result in cycle RL+r after the first load cycle.
    always @(negedge clk) begin
        if (!reset) begin
            g_act      = 1'b0;
            g          = 0;
            arr_result = {N{16'hA5A5}};
        end else begin
            if (!g_act && arr_load) begin
                g_act = 1'b1;
                g     = 0;
            end else if (g_act) begin
                g = g + 1;
            end
            if (g_act && g >= int'(RL) && g < int'(RL + N)) arr_result = row_val(tile_seed, g - int'(RL));
            else arr_result = {N{16'hA5A5}};
            if (g_act && g >= int'(RL + N - 1)) g_act = 1'b0;
        end
    end

    // Scoreboard: every accepted result row must match the oldest expected row.
    always @(negedge clk) begin
        if (reset === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra_row got=%h expected=none", res_row);
            end else begin
                logic [N*SW-1:0] e;
                e = exp_q.pop_front();
                if (res_row !== e) begin
                    errors++;
                    $display("FAIL scoreboard_row got=%h expected=%h", res_row, e);
                end
            end
        end
    end

    task automatic random_tile();
        for (int i = 0; i < int'(N); i++)
            for (int j = 0; j < int'(N); j++) begin
                a_mat[i][j] = DW'($urandom_range(0, 15));
                b_mat[i][j] = DW'($urandom_range(0, 15));
            end
    endtask

    task automatic push_expected(input logic [SW-1:0] seed);
        tile_seed = seed;
        for (int r = 0; r < int'(N); r++) exp_q.push_back(row_val(seed, r));
    endtask

    task automatic start_tile();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Gap-free operand beats; returns 1 time unit after the edge accepting the last beat.
    task automatic fill_tile();
        for (int k = 0; k < int'(N); k++) begin
            for (int i = 0; i < int'(N); i++) begin
                in_a_col[i*DW +: DW] = a_mat[i][k];
                in_b_row[i*DW +: DW] = b_mat[k][i];
            end
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        in_a_col = '0; in_b_row = '0; tile_seed = '0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, in_ready, arr_clear, arr_load, res_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b expected=000000", {busy, done, in_ready, arr_clear, arr_load, res_valid});
        end
        checks++;
        if (arr_vals !== '0 || arr_weights !== '0 || res_row !== '0) begin
            errors++;
            $display("FAIL reset_data vals=%h weights=%h row=%h expected=0", arr_vals, arr_weights, res_row);
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        checks++;
        if (perf_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf got=%0d expected=0", perf_cycles);
        end
`endif
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (arr_clear !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset clear=%b busy=%b ready=%b expected=1,0,0", arr_clear, busy, in_ready);
        end
    endtask

    task automatic test_reset_mid_feed();
        bit bad;
        random_tile();
        tile_seed = 16'h0100;
        start_tile();
        fill_tile();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, arr_load, res_valid, in_ready} !== 4'b0) begin
            errors++;
            $display("FAIL midfeed_async got=%b expected=0000", {busy, arr_load, res_valid, in_ready});
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, arr_load, res_valid, in_ready} !== 4'b0) begin
            errors++;
            $display("FAIL midfeed_after got=%b expected=0000", {busy, arr_load, res_valid, in_ready});
        end
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midfeed_no_done done_or_busy_seen=1 expected=0");
        end
    endtask

    task automatic test_feed_skew();
        int  hs, last_hs, cyc;
        bit  got;
        for (int i = 0; i < int'(N); i++)
            for (int j = 0; j < int'(N); j++) begin
                a_mat[i][j] = (i == j) ? DW'(1) : DW'(0);
                b_mat[i][j] = DW'(i + j);
            end
        push_expected(16'h0000);
        res_ready = 1'b1;
        start_tile();
        fill_tile();
        for (int t = 0; t < int'(2 * N - 1); t++) begin
            @(negedge clk);
            checks++;
            if (arr_load !== 1'b1 || arr_clear !== 1'b0) begin
                errors++;
                $display("FAIL feed_load t=%0d load=%b clear=%b expected=1,0", t, arr_load, arr_clear);
            end
            checks++;
            if (arr_vals !== exp_vals(t) || arr_weights !== exp_weights(t)) begin
                errors++;
                $display("FAIL feed_skew t=%0d vals=%h weights=%h expected=%h,%h",
                         t, arr_vals, arr_weights, exp_vals(t), exp_weights(t));
            end
            if (t == 3) begin
                checks++;
                if (arr_weights !== 16'h3333) begin
                    errors++;
                    $display("FAIL feed_t3_weights got=%h expected=3333", arr_weights);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (arr_load !== 1'b0 || arr_vals !== '0 || arr_weights !== '0) begin
            errors++;
            $display("FAIL feed_end load=%b vals=%h weights=%h expected=0", arr_load, arr_vals, arr_weights);
        end
        hs = 0; last_hs = -10; cyc = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (res_valid && res_ready) begin
                hs++;
                last_hs = cyc;
            end
            if (done) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL feed_done_timeout got=no_done expected=done");
        end else if (hs != int'(N) || cyc != last_hs + 1) begin
            errors++;
            $display("FAIL done_timing beats=%0d done_cycle=%0d expected=%0d,%0d", hs, cyc, N, last_hs + 1);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%b busy=%b expected=0,0", done, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL feed_rows_left got=%0d expected=0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        bit [3:0]        pat;
        bit              got, prev_stall, found;
        int              hs;
        logic [N*SW-1:0] held;
        pat = 4'b1001;
        random_tile();
        push_expected(16'hFFFA);
        res_ready = 1'b0;
        start_tile();
        fill_tile();
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (res_valid) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL stall_valid_timeout got=no_valid expected=valid");
            return;
        end
        prev_stall = 1'b1; held = res_row; hs = 0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1 res_ready = pat[c % 4];
            @(negedge clk);
            if (done) got = 1'b1;
            if (prev_stall && !got) begin
                checks++;
                if (res_valid !== 1'b1 || res_row !== held) begin
                    errors++;
                    $display("FAIL stall_hold valid=%b row=%h expected=1,%h", res_valid, res_row, held);
                end
            end
            prev_stall = res_valid && !res_ready;
            held = res_row;
            if (res_valid && res_ready) hs++;
        end
        res_ready = 1'b0;
        checks++;
        if (!got || hs != int'(N)) begin
            errors++;
            $display("FAIL stall_beats done=%b beats=%0d expected=1,%0d", got, hs, N);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_end valid=%b rows_left=%0d expected=0,0", res_valid, exp_q.size());
        end
    endtask

    task automatic test_gapped();
        bit got;
        random_tile();
        push_expected(16'h7FF0);
        res_ready = 1'b1;
        start_tile();
        for (int k = 0; k < int'(N); k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < int'(N); i++) begin
                in_a_col[i*DW +: DW] = a_mat[i][k];
                in_b_row[i*DW +: DW] = b_mat[k][i];
            end
            in_valid = 1'b1;
            start = 1'b0;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || arr_load !== 1'b0) begin
                errors++;
                $display("FAIL gap_fill k=%0d ready=%b load=%b expected=1,0", k, in_ready, arr_load);
            end
            if (k < int'(N) - 1) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_a_col = N*DW'($urandom);
                in_b_row = N*DW'($urandom);
                start = 1'b1;
            end
        end
        // Junk beats and start pulses while feeding must be ignored.
        @(posedge clk); #1;
        in_a_col = N*DW'($urandom);
        in_b_row = N*DW'($urandom);
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (arr_load !== 1'b1 || in_ready !== 1'b0 || arr_vals !== exp_vals(0)) begin
            errors++;
            $display("FAIL gap_feed_start load=%b ready=%b vals=%h expected=1,0,%h", arr_load, in_ready, arr_vals, exp_vals(0));
        end
        for (int t = 1; t < int'(2 * N - 1); t++) begin
            @(posedge clk); #1;
            in_a_col = N*DW'($urandom);
            in_b_row = N*DW'($urandom);
            start = t[0];
            @(negedge clk);
            checks++;
            if (arr_vals !== exp_vals(t) || arr_weights !== exp_weights(t)) begin
                errors++;
                $display("FAIL gap_feed t=%0d vals=%h weights=%h expected=%h,%h",
                         t, arr_vals, arr_weights, exp_vals(t), exp_weights(t));
            end
        end
        in_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(posedge clk); #1 start = ((c % 2) == 0) && !res_valid;
            @(negedge clk);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL gap_done_timeout got=no_done expected=done");
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL gap_start_ignored busy=%b rows_left=%0d expected=0,0", busy, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        random_tile();
        push_expected(16'h0020);
        res_ready = 1'b1;
        start_tile();
        fill_tile();
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL b2b_done1_timeout got=no_done expected=done");
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        checks++;
        if (perf_cycles !== 32'd20) begin
            errors++;
            $display("FAIL perf_at_done got=%0d expected=20", perf_cycles);
        end
`endif
        // Start raised inside the done cycle must launch the next tile.
        random_tile();
        push_expected(16'h8003);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start busy=%b ready=%b expected=1,1", busy, in_ready);
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        checks++;
        if (perf_cycles !== 32'd0) begin
            errors++;
            $display("FAIL perf_cleared got=%0d expected=0", perf_cycles);
        end
`endif
        fill_tile();
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        checks++;
        if (!got || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_done2 done=%b rows_left=%0d expected=1,0", got, exp_q.size());
        end
`ifdef SYSTOLIC_CTRL_PERF_EN
        checks++;
        if (perf_cycles !== 32'd20) begin
            errors++;
            $display("FAIL perf_second_tile got=%0d expected=20", perf_cycles);
        end
`endif
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_feed();
        test_feed_skew();
        test_stall();
        test_gapped();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
